// File: rtl/hp_pkg.sv
// Shared types and register map for the host-programmer (passive-serial) core.
package hp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NCFG_LOW = 3'd1,
    ST_WAIT_NST = 3'd2,
    ST_LOAD     = 3'd3,
    ST_INIT     = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } hp_state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_MSEL_LSB = 4;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_DONE      = 1;
  localparam int unsigned STAT_ERROR     = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_EMPTY     = 4;
  localparam int unsigned STAT_OVERFLOW  = 5;
  localparam int unsigned STAT_STATE_LSB = 8;

endpackage

// File: rtl/hp_fifo.sv
// Synchronous byte FIFO with flush; show-ahead read data, registered flags.
module hp_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [7:0]                 wdata,
  input  logic                       pop,
  output logic [7:0]                 rdata_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_d;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata_c = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (flush)                 level_d = '0;
    else if (do_push && !do_pop) level_d = level + LW'(1);
    else if (do_pop && !do_push) level_d = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/hp_top.sv
// Host-programmer core: register bus in, Altera passive-serial configuration out.
// Define HP_MSB_FIRST_EN to shift each byte MSB-first instead of LSB-first.
module hp_top
  import hp_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned NCFG_LOW_CYCLES = 100,
  parameter int unsigned NSTATUS_TIMEOUT = 100000,
  parameter int unsigned INIT_CLKS       = 64,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rd,
  output logic [31:0] bus_rdata,
  output logic        n_config,
  input  logic        n_status,
  input  logic        conf_done,
  output logic        dclk,
  output logic        data,
  output logic [3:0]  msel
);

  localparam int unsigned CW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 16;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  hp_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [IW-1:0] init_cnt, init_d;
  logic [2:0]    bit_cnt, bit_d;
  logic          have_byte, byte_d;
  logic [7:0]    shreg, shreg_d;
  logic          ncfg_d, dclk_d, data_d;
  logic          done_f, done_d, err_f, err_d, ovf_f, ovf_d;
  logic          nst_meta, nst_s, cd_meta, cd_s;
  logic          wr_ctrl, wr_data, start, abort, busy, div_hit, nst_lost;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          load_bit, next_bit;
  logic [7:0]    load_rest, next_rest;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign wr_ctrl  = bus_wr && (bus_addr == REG_CTRL);
  assign wr_data  = bus_wr && (bus_addr == REG_DATA);
  assign start    = wr_ctrl && bus_wdata[CTRL_START];
  assign abort    = wr_ctrl && bus_wdata[CTRL_ABORT];
  assign busy     = (state == ST_NCFG_LOW) || (state == ST_WAIT_NST) ||
                    (state == ST_LOAD) || (state == ST_INIT);
  assign div_hit  = (div_cnt == DW'(CLK_DIV - 1));
  assign nst_lost = !nst_s && ((state == ST_LOAD) || (state == ST_INIT));
  assign unused_bits = ^{bus_wdata[31:8], bus_wdata[3:2], fifo_level};

`ifdef HP_MSB_FIRST_EN
  assign load_bit  = fifo_rdata[7];
  assign load_rest = {fifo_rdata[6:0], 1'b0};
  assign next_bit  = shreg[7];
  assign next_rest = {shreg[6:0], 1'b0};
`else
  assign load_bit  = fifo_rdata[0];
  assign load_rest = {1'b0, fifo_rdata[7:1]};
  assign next_bit  = shreg[0];
  assign next_rest = {1'b0, shreg[7:1]};
`endif

  hp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (sysclk),
    .rst     (rst),
    .flush   (abort),
    .push    (wr_data),
    .wdata   (bus_wdata[7:0]),
    .pop     (fifo_pop),
    .rdata_c (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Next-state and next-output logic for the configuration sequencer.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    div_d    = div_cnt;
    init_d   = init_cnt;
    bit_d    = bit_cnt;
    byte_d   = have_byte;
    shreg_d  = shreg;
    ncfg_d   = n_config;
    dclk_d   = dclk;
    data_d   = data;
    done_d   = done_f;
    err_d    = err_f;
    ovf_d    = ovf_f;
    fifo_pop = 1'b0;

    if (wr_data && fifo_full) ovf_d = 1'b1;

    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_NCFG_LOW;
          ncfg_d  = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_NCFG_LOW: begin
        if (cnt == CW'(NCFG_LOW_CYCLES - 1)) begin
          state_d = ST_WAIT_NST;
          ncfg_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_WAIT_NST: begin
        if (nst_s) begin
          state_d = ST_LOAD;
          byte_d  = 1'b0;
          dclk_d  = 1'b0;
          div_d   = '0;
        end else if (cnt == CW'(NSTATUS_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_LOAD: begin
        // Byte boundary: dclk is low here; conf_done wins over fetching more data.
        if (!have_byte) begin
          if (cd_s) begin
            state_d = ST_INIT;
            data_d  = 1'b0;
            div_d   = '0;
            init_d  = '0;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = load_bit;
            shreg_d  = load_rest;
            bit_d    = '0;
            byte_d   = 1'b1;
            div_d    = '0;
          end
        end else if (div_hit) begin
          div_d  = '0;
          dclk_d = !dclk;
          if (dclk) begin
            if (bit_cnt == 3'd7) begin
              byte_d = 1'b0;
            end else begin
              bit_d   = bit_cnt + 3'd1;
              data_d  = next_bit;
              shreg_d = next_rest;
            end
          end
        end else begin
          div_d = div_cnt + DW'(1);
        end
      end
      ST_INIT: begin
        if (div_hit) begin
          div_d  = '0;
          dclk_d = !dclk;
          if (dclk) begin
            if (init_cnt == IW'(INIT_CLKS - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              init_d = init_cnt + IW'(1);
            end
          end
        end else begin
          div_d = div_cnt + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (nst_lost) begin
      state_d  = ST_ERROR;
      err_d    = 1'b1;
      done_d   = done_f;
      ncfg_d   = 1'b1;
      dclk_d   = 1'b0;
      data_d   = 1'b0;
      byte_d   = 1'b0;
      fifo_pop = 1'b0;
    end

    if (abort) begin
      state_d  = ST_IDLE;
      ncfg_d   = 1'b1;
      dclk_d   = 1'b0;
      data_d   = 1'b0;
      byte_d   = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus_addr)
      REG_CTRL:   rd_mux[CTRL_MSEL_LSB +: 4] = msel;
      REG_STATUS: begin
        rd_mux[STAT_BUSY]              = busy;
        rd_mux[STAT_DONE]              = done_f;
        rd_mux[STAT_ERROR]             = err_f;
        rd_mux[STAT_FULL]              = fifo_full;
        rd_mux[STAT_EMPTY]             = fifo_empty;
        rd_mux[STAT_OVERFLOW]          = ovf_f;
        rd_mux[STAT_STATE_LSB +: 4]    = 4'(state);
      end
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      div_cnt   <= '0;
      init_cnt  <= '0;
      bit_cnt   <= '0;
      have_byte <= 1'b0;
      shreg     <= '0;
      done_f    <= 1'b0;
      err_f     <= 1'b0;
      ovf_f     <= 1'b0;
      nst_meta  <= 1'b0;
      nst_s     <= 1'b0;
      cd_meta   <= 1'b0;
      cd_s      <= 1'b0;
      n_config  <= 1'b1;
      dclk      <= 1'b0;
      data      <= 1'b0;
      msel      <= '0;
      bus_rdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      div_cnt   <= div_d;
      init_cnt  <= init_d;
      bit_cnt   <= bit_d;
      have_byte <= byte_d;
      shreg     <= shreg_d;
      done_f    <= done_d;
      err_f     <= err_d;
      ovf_f     <= ovf_d;
      nst_meta  <= n_status;
      nst_s     <= nst_meta;
      cd_meta   <= conf_done;
      cd_s      <= cd_meta;
      n_config  <= ncfg_d;
      dclk      <= dclk_d;
      data      <= data_d;
      if (wr_ctrl) msel <= bus_wdata[CTRL_MSEL_LSB +: 4];
      if (bus_rd)  bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hp_top.sv
// Directed bench for hp_top: bit-stream queue model, pulse/period monitor, literal STATUS checks.
module tb_hp_top;

  localparam int unsigned NCFG       = 100;
  localparam int unsigned TB_TIMEOUT = 2000;   // shortened n_status timeout keeps the run brief
  localparam int unsigned INIT_N     = 64;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_rdata;
  logic        n_config;
  logic        n_status = 1'b0;
  logic        conf_done = 1'b0;
  logic        dclk;
  logic        data;
  logic [3:0]  msel;

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   exp_bits[$];
  bit   obs_bits[$];
  int   ncfg_len = 0;
  int   gap = 0;
  int   bit_pos = 0;
  int   init_rises = 0;
  logic dclk_q = 1'b0;
  logic [3:0] m_msel = '0;

  hp_top #(.NSTATUS_TIMEOUT(TB_TIMEOUT)) dut (
    .sysclk(sysclk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .n_config(n_config), .n_status(n_status), .conf_done(conf_done),
    .dclk(dclk), .data(data), .msel(msel)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge sysclk); #2;
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(posedge sysclk); #2;
    bus_wr = 1'b0;
    if (a == 2'd0) m_msel = d[7:4];
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge sysclk); #2;
    bus_addr = a; bus_rd = 1'b1;
    @(posedge sysclk); #2;
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
`ifdef HP_MSB_FIRST_EN
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
`else
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`endif
    bus_write(2'd2, 32'(b));
  endtask

  task automatic wait_bits(input int left, input string name);
    for (int i = 0; i < 400 && exp_bits.size() > left; i++) cyc(1);
    check(name, 32'(exp_bits.size()), 32'(left));
  endtask

  task automatic model_flush();
    exp_bits.delete();
    bit_pos = 0;
  endtask

  // Every-cycle compare: msel, n_config pulse width, serial bits at dclk rising edges.
  always @(negedge sysclk) begin
    if (mon_en) begin
      check("msel", 32'(msel), 32'(m_msel));
      if (!n_config) begin
        ncfg_len++;
        check("dclk_during_ncfg", 32'(dclk), 32'h0);
      end else if (ncfg_len != 0) begin
        check("ncfg_low_len", 32'(ncfg_len), 32'(NCFG));
        ncfg_len = 0;
      end
      gap++;
      if (dclk && !dclk_q) begin
        if (exp_bits.size() != 0) begin
          bit eb;
          eb = exp_bits.pop_front();
          check("data_bit", 32'(data), 32'(eb));
          obs_bits.push_back(data);
          if (bit_pos != 0) check("dclk_period", 32'(gap), 32'd4);
          bit_pos = (bit_pos + 1) % 8;
        end else begin
          check("init_data", 32'(data), 32'h0);
          init_rises++;
        end
        gap = 0;
      end
      dclk_q = dclk;
    end
  end

  initial begin
    logic [31:0] st;
    logic [7:0]  w;

    cyc(3);
    check("rst_n_config", 32'(n_config), 32'h1);
    check("rst_dclk", 32'(dclk), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_msel", 32'(msel), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    rst = 1'b0;
    cyc(2);
    mon_en = 1'b1;
    bus_read(2'd1, st);
    check("status_after_reset", st, 32'h0010);

    // n_status never rises: n_config pulse, then timeout into ERROR
    bus_write(2'd0, 32'h51);
    cyc(NCFG + TB_TIMEOUT - 100);
    bus_read(2'd1, st);
    check("status_wait_nst", st, 32'h0211);
    cyc(200);
    bus_read(2'd1, st);
    check("status_timeout", st, 32'h0614);
    bus_read(2'd0, st);
    check("ctrl_readback", st, 32'h50);
    bus_read(2'd3, st);
    check("reg3_zero", st, 32'h0);

    // single byte 0xA5 through the serial port
    bus_write(2'd0, 32'h51);
    cyc(50);
    n_status = 1'b1;
    cyc(120);
    bus_read(2'd1, st);
    check("status_load_stall", st, 32'h0311);
    obs_bits.delete();
    push_byte(8'hA5);
    wait_bits(0, "a5_drain");
    check("a5_bit_count", 32'(obs_bits.size()), 32'd8);
    w = '0;
    for (int i = 0; i < 8 && i < obs_bits.size(); i++) w[7-i] = obs_bits[i];
    check("a5_sequence", 32'(w), 32'hA5);

    // three bytes, then conf_done -> INIT clocks -> DONE
    push_byte(8'h3C);
    push_byte(8'h81);
    push_byte(8'h5E);
    wait_bits(0, "three_drain");
    init_rises = 0;
    conf_done = 1'b1;
    st = '0;
    for (int i = 0; i < 300; i++) begin
      bus_read(2'd1, st);
      if (st[1]) break;
    end
    check("status_done", st, 32'h0512);
    check("init_pulses", 32'(init_rises), 32'(INIT_N));

    // n_status lost mid-byte
    conf_done = 1'b0;
    bus_write(2'd0, 32'h51);
    cyc(NCFG + 10);
    bus_read(2'd1, st);
    check("status_load_again", st, 32'h0311);
    push_byte(8'hFF);
    wait_bits(4, "ff_half");
    n_status = 1'b0;
    cyc(3);
    check("nst_lost_dclk", 32'(dclk), 32'h0);
    check("nst_lost_ncfg", 32'(n_config), 32'h1);
    model_flush();
    bus_read(2'd1, st);
    check("status_nst_lost", st, 32'h0614);

    // overflow, abort flush, start clears sticky bits (error stays set across abort)
    bus_write(2'd0, 32'h02);
    for (int i = 0; i < 17; i++) bus_write(2'd2, 32'(i));
    bus_read(2'd1, st);
    check("status_overflow", st, 32'h002C);
    bus_write(2'd0, 32'h02);
    bus_read(2'd1, st);
    check("status_flushed", st, 32'h0034);
    bus_write(2'd0, 32'h51);
    bus_read(2'd1, st);
    check("status_restart", st, 32'h0111);
    cyc(110);
    bus_write(2'd0, 32'h02);
    bus_read(2'd1, st);
    check("status_aborted", st, 32'h0010);

    // reset in the middle of a byte
    n_status = 1'b1;
    bus_write(2'd0, 32'h51);
    cyc(NCFG + 10);
    push_byte(8'h0F);
    wait_bits(5, "rst_partial");
    rst = 1'b1;
    mon_en = 1'b0;
    model_flush();
    m_msel = '0;
    #1;
    check("midrst_n_config", 32'(n_config), 32'h1);
    check("midrst_dclk", 32'(dclk), 32'h0);
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_msel", 32'(msel), 32'h0);
    check("midrst_rdata", bus_rdata, 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    dclk_q = 1'b0;
    ncfg_len = 0;
    gap = 0;
    mon_en = 1'b1;
    bus_read(2'd1, st);
    check("status_after_midrst", st, 32'h0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
